// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage next-PC controller: FSM encoding,
// sequential PC step and default reset/exception addresses.
package pc_pkg;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } pc_state_e;

    localparam int unsigned PC_STEP        = 4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pc_fetch_ctrl_next_mux.sv
// Combinational next-PC priority select, next FSM state and wrong-path flush generation.
// Exception path is compiled in only when PC_FETCH_EXC_EN is defined.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = 32
`ifdef PC_FETCH_EXC_EN
   ,parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(DEF_EXC_VECTOR)
`endif
) (
    input  pc_state_e             state_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    input  logic                  stall_i,
    input  logic                  jump_i,
    input  logic [PC_WIDTH-1:0]   jump_target_i,
    input  logic                  branch_taken_i,
    input  logic [PC_WIDTH-1:0]   branch_target_i,
    input  logic                  halt_req_i,
    input  logic                  resume_i,
`ifdef PC_FETCH_EXC_EN
    input  logic                  exc_req_i,
    output logic                  exc_take_o,
`endif
    output logic [PC_WIDTH-1:0]   pc_plus4_o,
    output logic [PC_WIDTH-1:0]   pc_next_o,
    output pc_state_e             state_next_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o
);

    logic [PC_WIDTH-1:0] jump_aligned;
    logic [PC_WIDTH-1:0] branch_aligned;

    assign pc_plus4_o     = pc_i + PC_WIDTH'(PC_STEP);
    assign jump_aligned   = {jump_target_i[PC_WIDTH-1:2], 2'b00};
    assign branch_aligned = {branch_target_i[PC_WIDTH-1:2], 2'b00};

    always_comb begin
        pc_next_o     = pc_i;
        state_next_o  = state_i;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
`ifdef PC_FETCH_EXC_EN
        exc_take_o    = 1'b0;
        if (exc_req_i) begin
            pc_next_o     = EXC_VECTOR;
            state_next_o  = S_RUN;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            exc_take_o    = 1'b1;
        end else
`endif
        if (state_i == S_HALT) begin
            if (resume_i) begin
                state_next_o = S_RUN;
            end
        end else if (branch_taken_i) begin
            // Branch in EX is older than any jump in ID, so the jump is dropped.
            pc_next_o     = branch_aligned;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (jump_i) begin
            pc_next_o     = jump_aligned;
            if_id_flush_o = 1'b1;
        end else if (halt_req_i) begin
            if_id_flush_o = 1'b1;
            state_next_o  = S_HALT;
        end else if (!stall_i) begin
            pc_next_o = pc_plus4_o;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC owner: PC register, RUN/HALT FSM, saturating fetch counter and,
// when PC_FETCH_EXC_EN is defined, exception redirect with saved EPC.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEF_RESET_PC),
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(DEF_EXC_VECTOR),
    parameter int unsigned         CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  jump,
    input  logic [PC_WIDTH-1:0]   jump_target,
    input  logic                  branch_taken,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic                  halt_req,
    input  logic                  resume,
`ifdef PC_FETCH_EXC_EN
    input  logic                  exc_req,
    input  logic [PC_WIDTH-1:0]   exc_pc,
    output logic [PC_WIDTH-1:0]   epc,
`endif
    output logic [PC_WIDTH-1:0]   pc,
    output logic [PC_WIDTH-1:0]   pc_plus4,
    output logic                  fetch_valid,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  fetch_count
);

    pc_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  mux_if_flush;
    logic                  mux_id_flush;

`ifdef PC_FETCH_EXC_EN
    logic                  exc_take;
    logic [PC_WIDTH-1:0]   epc_q, epc_d;
`else
    logic                  unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    pc_next_mux #(
        .PC_WIDTH        (PC_WIDTH)
`ifdef PC_FETCH_EXC_EN
       ,.EXC_VECTOR      (EXC_VECTOR)
`endif
    ) u_next_mux (
        .state_i         (state_q),
        .pc_i            (pc_q),
        .stall_i         (stall),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .halt_req_i      (halt_req),
        .resume_i        (resume),
`ifdef PC_FETCH_EXC_EN
        .exc_req_i       (exc_req),
        .exc_take_o      (exc_take),
`endif
        .pc_plus4_o      (pc_plus4),
        .pc_next_o       (pc_d),
        .state_next_o    (state_d),
        .if_id_flush_o   (mux_if_flush),
        .id_ex_flush_o   (mux_id_flush)
    );

    // While reset is held every 1-bit output must read 0, flushes included.
    assign fetch_valid = (state_q == S_RUN) && !stall && reset;
    assign if_id_flush = mux_if_flush && reset;
    assign id_ex_flush = mux_id_flush && reset;
    assign halted      = (state_q == S_HALT);
    assign pc          = pc_q;
    assign fetch_count = count_q;

    always_comb begin
        count_d = count_q;
        if (fetch_valid && !if_id_flush && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

`ifdef PC_FETCH_EXC_EN
    assign epc = epc_q;

    always_comb begin
        epc_d = epc_q;
        if (exc_take) begin
            epc_d = exc_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model. Honours PC_FETCH_EXC_EN.
module tb_pc_fetch_ctrl;

    localparam int          CW       = 6;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_0080;
`ifdef PC_FETCH_EXC_EN
    localparam bit          EXC_ON   = 1'b1;
`else
    localparam bit          EXC_ON   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0, jump = 1'b0, branch_taken = 1'b0;
    logic          halt_req = 1'b0, resume = 1'b0, exc_req = 1'b0;
    logic [31:0]   jump_target = '0, branch_target = '0, exc_pc = '0;
    logic [31:0]   pc, pc_plus4, epc_obs;
    logic          fetch_valid, if_id_flush, id_ex_flush, halted;
    logic [CW-1:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    int cyc      = 0;

    always #5 clk = ~clk;

`ifdef PC_FETCH_EXC_EN
    logic [31:0] epc;
    assign epc_obs = epc;
`else
    assign epc_obs = '0;
`endif

    pc_fetch_ctrl #(
        .PC_WIDTH      (32),
        .RESET_PC      (RST_PC),
        .EXC_VECTOR    (EXC_VEC),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
`ifdef PC_FETCH_EXC_EN
        .exc_req       (exc_req),
        .exc_pc        (exc_pc),
        .epc           (epc),
`endif
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]   m_pc   = RST_PC;
    logic [31:0]   m_epc  = '0;
    logic          m_halt = 1'b0;
    int            m_cnt  = 0;
    logic          m_exc;
    int            max_cnt;

    assign m_exc   = EXC_ON && exc_req;
    assign max_cnt = (1 << CW) - 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc   <= RST_PC;
            m_epc  <= '0;
            m_halt <= 1'b0;
            m_cnt  <= 0;
        end else if (m_exc) begin
            m_pc   <= EXC_VEC;
            m_epc  <= exc_pc;
            m_halt <= 1'b0;
        end else if (m_halt) begin
            if (resume) m_halt <= 1'b0;
        end else begin
            if (!stall && !branch_taken && !jump && !halt_req && m_cnt < max_cnt)
                m_cnt <= m_cnt + 1;
            if (branch_taken)      m_pc <= branch_target & ~32'd3;
            else if (jump)         m_pc <= jump_target & ~32'd3;
            else if (halt_req)     m_halt <= 1'b1;
            else if (!stall)       m_pc <= m_pc + 32'd4;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            logic e_fv, e_if, e_id;
            e_fv = reset && !m_halt && !stall;
            e_if = reset && (m_exc || (!m_halt && (branch_taken || jump || halt_req)));
            e_id = reset && (m_exc || (!m_halt && branch_taken));
            cyc++;
            check("pc",          pc,                      m_pc);
            check("pc_plus4",    pc_plus4,                m_pc + 32'd4);
            check("fetch_valid", 32'(fetch_valid),        32'(e_fv));
            check("if_id_flush", 32'(if_id_flush),        32'(e_if));
            check("id_ex_flush", 32'(id_ex_flush),        32'(e_id));
            check("halted",      32'(halted),             32'(m_halt));
            check("fetch_count", 32'(fetch_count),        32'(m_cnt));
            if (EXC_ON) check("epc", epc_obs, m_epc);
            $display("cyc %0d rst=%b pc=%h fv=%b fl=%b%b halt=%b cnt=%0d", cyc, reset, pc,
                     fetch_valid, if_id_flush, id_ex_flush, halted, fetch_count);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        stall = 0; jump = 0; branch_taken = 0; halt_req = 0; resume = 0; exc_req = 0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        @(posedge clk);
        cmp_en = 1'b1;
        #2;
        repeat (3) step();
        check("rst_pc", pc, 32'h0);
        check("rst_cnt", 32'(fetch_count), 32'd0);
        check("rst_fv", 32'(fetch_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        reset = 1;
        repeat (4) step();
        check("seq_pc", pc, 32'h10);
        check("seq_cnt", 32'(fetch_count), 32'd4);

        #1 reset = 0;
        #1 check("async_rst_pc", pc, 32'h0);
        check("async_rst_cnt", 32'(fetch_count), 32'd0);
        step();
        reset = 1;
        step(); step();
        check("pre_stall_pc", pc, 32'h8);

        stall = 1;
        #1 check("stall_fv", 32'(fetch_valid), 32'd0);
        step(); step();
        check("stall_pc", pc, 32'h8);
        check("stall_cnt", 32'(fetch_count), 32'd2);
        stall = 0;
        step();
        check("unstall_pc", pc, 32'hC);
        step();

        branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h80; stall = 1;
        #1 check("br_if_flush", 32'(if_id_flush), 32'd1);
        check("br_id_flush", 32'(id_ex_flush), 32'd1);
        step();
        clear_inputs();
        check("br_pc", pc, 32'h40);
        check("br_cnt", 32'(fetch_count), 32'd4);

        jump = 1; jump_target = 32'h103;
        #1 check("j_if_flush", 32'(if_id_flush), 32'd1);
        check("j_id_flush", 32'(id_ex_flush), 32'd0);
        step();
        clear_inputs();
        check("j_pc", pc, 32'h100);

        branch_taken = 1; branch_target = 32'h20;
        step();
        clear_inputs();
        halt_req = 1;
        step();
        clear_inputs();
        check("halt_halted", 32'(halted), 32'd1);
        jump = 1; jump_target = 32'h80; branch_taken = 1; branch_target = 32'h40; stall = 1;
        #1 check("halt_no_flush", 32'(if_id_flush), 32'd0);
        step(); step();
        check("halt_hold_pc", pc, 32'h20);
        clear_inputs();
        resume = 1;
        step();
        resume = 0;
        check("resume_halted", 32'(halted), 32'd0);
        step();
        check("resume_pc", pc, 32'h24);
        check("resume_cnt", 32'(fetch_count), 32'd5);

        branch_taken = 1; branch_target = 32'hFFFF_FFFE;
        step();
        clear_inputs();
        check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_cnt", 32'(fetch_count), 32'd6);

        if (EXC_ON) begin
            exc_req = 1; exc_pc = 32'h44; jump = 1; jump_target = 32'h200;
            #1 check("exc_id_flush", 32'(id_ex_flush), 32'd1);
            step();
            clear_inputs();
            check("exc_pc", pc, 32'h80);
            check("exc_epc", epc_obs, 32'h44);
        end

        for (int i = 0; i < 1500; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 9) == 0);
            branch_taken  = ($urandom_range(0, 11) == 0);
            halt_req      = ($urandom_range(0, 19) == 0);
            resume        = ($urandom_range(0, 2) == 0);
            exc_req       = ($urandom_range(0, 19) == 0);
            jump_target   = $urandom();
            branch_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : $urandom();
            exc_pc        = $urandom();
            reset         = ($urandom_range(0, 63) != 0);
            step();
        end

        clear_inputs();
        reset = 1;
        resume = 1;
        step();
        resume = 0;
        repeat (70) step();
        check("sat_cnt", 32'(fetch_count), 32'(max_cnt));

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
